// File: rtl/ir_block_loader.sv
// Instruction block loader: fetches 8-word blocks from memory and holds each
// one until the downstream controller accepts it, supporting jumps and stop.
//
// state   | meaning
// FETCH   | requesting beats o_pc+idx, one word per accepted ack
// HOLD    | full block presented on o_block, waiting for i_block_ready
// STOPPED | idle, no requests; leaves only on i_jump or rst
module ir_block_loader #(
  parameter int IR_WIDTH   = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_jump,
  input  logic [ADDR_WIDTH-1:0]     i_jump_addr,
  input  logic                      i_stop,
  output logic                      o_mem_req,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  input  logic                      i_mem_ack,
  input  logic [IR_WIDTH-1:0]       i_mem_data,
  output logic [8*IR_WIDTH-1:0]     o_block,
  output logic                      o_block_valid,
  input  logic                      i_block_ready,
  output logic [ADDR_WIDTH-1:0]     o_pc
);

  localparam int BLOCK_WORDS = 8;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    STOPPED = 2'd2
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_idx;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic                    r_mem_req;
  logic                    r_block_valid;
  logic [8*IR_WIDTH-1:0]   r_block;

  logic                    w_beat;
  logic [2:0]              w_idx_inc;
  logic [ADDR_WIDTH-1:0]   w_addr_next;
  logic [ADDR_WIDTH-1:0]   w_pc_next_blk;

  // An ack only counts while a request is actually outstanding.
  assign w_beat        = r_mem_req & i_mem_ack;
  assign w_idx_inc     = r_idx + 3'd1;
  assign w_addr_next   = r_pc + ADDR_WIDTH'(w_idx_inc);
  assign w_pc_next_blk = r_pc + ADDR_WIDTH'(BLOCK_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_idx         <= 3'd0;
      r_pc          <= '0;
      r_mem_addr    <= '0;
      r_mem_req     <= 1'b1;
      r_block_valid <= 1'b0;
      r_block       <= '0;
    end else if (i_jump) begin
      // Jump wins over stop, acks and handshakes; any acked beat is dropped.
      r_state       <= FETCH;
      r_idx         <= 3'd0;
      r_pc          <= i_jump_addr;
      r_mem_addr    <= i_jump_addr;
      r_mem_req     <= 1'b1;
      r_block_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_stop) begin
            r_state   <= STOPPED;
            r_idx     <= 3'd0;
            r_mem_req <= 1'b0;
          end else if (w_beat) begin
            r_block[r_idx*IR_WIDTH +: IR_WIDTH] <= i_mem_data;
            r_idx      <= w_idx_inc;
            r_mem_addr <= w_addr_next;
            if (r_idx == 3'd7) begin
              r_state       <= HOLD;
              r_mem_req     <= 1'b0;
              r_block_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (i_stop) begin
            r_state       <= STOPPED;
            r_idx         <= 3'd0;
            r_block_valid <= 1'b0;
          end else if (i_block_ready) begin
            r_state       <= FETCH;
            r_idx         <= 3'd0;
            r_pc          <= w_pc_next_blk;
            r_mem_addr    <= w_pc_next_blk;
            r_mem_req     <= 1'b1;
            r_block_valid <= 1'b0;
          end
        end
        STOPPED: begin
          r_mem_req     <= 1'b0;
          r_block_valid <= 1'b0;
        end
        default: begin
          r_state       <= STOPPED;
          r_mem_req     <= 1'b0;
          r_block_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_block       = r_block;
  assign o_block_valid = r_block_valid;
  assign o_pc          = r_pc;

endmodule
